// File: rtl/bcd_round_ctrl.sv
// BCD switch game sequencer: button conditioning, LFSR target draw, round timing,
// 2-of-5 code judging, score and round bookkeeping.

module bcd_round_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic press_o
);
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          prev_q;
  logic          press_q;

  // Level flips only after DEBOUNCE_CYC consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;
endmodule

module bcd_round_ctrl #(
  parameter int         NUM_ROUNDS   = 10,
  parameter int         TIMEOUT_CYC  = 200000000,
  parameter int         DEBOUNCE_CYC = 1000000,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_i,
  input  logic       start_i,
  input  logic [4:0] sw_i,
  output logic [3:0] target_o,
  output logic [3:0] score_o,
  output logic [3:0] round_o,
  output logic       playing_o,
  output logic       game_over_o,
  output logic       hit_o,
  output logic       miss_o,
  output logic       timeout_o
);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  state_t        state_q;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [TW-1:0] timer_q;
  logic [3:0]    target_q, draw_d, score_q, round_q, round_d;
  logic          playing_q, game_over_q, hit_q, miss_q, timeout_q;
  logic          btn_press, start_press, match, timer_end;
  logic [4:0]    code;

  // Returns {valid, digit}; only the ten 2-of-5 patterns are valid.
  function automatic logic [4:0] decode_sw(input logic [4:0] sw);
    case (sw)
      5'b11000: decode_sw = 5'b1_0000;
      5'b00011: decode_sw = 5'b1_0001;
      5'b00101: decode_sw = 5'b1_0010;
      5'b00110: decode_sw = 5'b1_0011;
      5'b01001: decode_sw = 5'b1_0100;
      5'b01010: decode_sw = 5'b1_0101;
      5'b01100: decode_sw = 5'b1_0110;
      5'b10001: decode_sw = 5'b1_0111;
      5'b10010: decode_sw = 5'b1_1000;
      5'b10100: decode_sw = 5'b1_1001;
      default:  decode_sw = 5'b0_0000;
    endcase
  endfunction

  function automatic logic [3:0] draw_digit(input logic [3:0] raw, input logic [3:0] cur);
    logic [3:0] t;
    t = (raw >= 4'd10) ? raw - 4'd10 : raw;
    if (t == cur) begin
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end
    return t;
  endfunction

  bcd_round_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_db (
    .clk_i(clk_i), .rst_ni(rst_ni), .raw_i(btn_i), .press_o(btn_press)
  );

  bcd_round_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_db (
    .clk_i(clk_i), .rst_ni(rst_ni), .raw_i(start_i), .press_o(start_press)
  );

  // Next-state helpers for the sequencer.
  always_comb begin
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    draw_d    = draw_digit(lfsr_q[3:0], target_q);
    code      = decode_sw(sw_i);
    match     = code[4] && (code[3:0] == target_q);
    round_d   = round_q + 4'd1;
    timer_end = (timer_q == TW'(TIMEOUT_CYC - 1));
  end

  // Game FSM with registered outputs; a press on the timeout cycle takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      timer_q     <= '0;
      target_q    <= 4'd0;
      score_q     <= 4'd0;
      round_q     <= 4'd0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (start_press) begin
            state_q     <= PLAY;
            score_q     <= 4'd0;
            round_q     <= 4'd0;
            target_q    <= draw_d;
            timer_q     <= '0;
            playing_q   <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        PLAY: begin
          if (btn_press || timer_end) begin
            if (btn_press && match) begin
              hit_q   <= 1'b1;
              score_q <= score_q + 4'd1;
            end else begin
              miss_q    <= 1'b1;
              timeout_q <= ~btn_press;
            end
            round_q <= round_d;
            timer_q <= '0;
            if (round_d == 4'(NUM_ROUNDS)) begin
              state_q     <= OVER;
              playing_q   <= 1'b0;
              game_over_q <= 1'b1;
            end else begin
              target_q <= draw_d;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          playing_q   <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign target_o    = target_q;
  assign score_o     = score_q;
  assign round_o     = round_q;
  assign playing_o   = playing_q;
  assign game_over_o = game_over_q;
  assign hit_o       = hit_q;
  assign miss_o      = miss_q;
  assign timeout_o   = timeout_q;
endmodule
